// File: rtl/rnn_gain_apply.sv
// Per-band RNN gain applied to one frame of complex spectrum bins.
// Optional macro RNN_GAIN_FLOOR_EN: stored gains are raised to GAIN_FLOOR.
module rnn_gain_apply #(
  parameter int          NB_BANDS      = 22,
  parameter int          BINS_PER_BAND = 8,
  parameter logic [15:0] GAIN_FLOOR    = 16'd328
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gain_valid,
  output logic        gain_ready,
  input  logic [15:0] gain_data,
  input  logic        bin_in_valid,
  output logic        bin_in_ready,
  input  logic [15:0] bin_in_re,
  input  logic [15:0] bin_in_im,
  output logic        bin_out_valid,
  input  logic        bin_out_ready,
  output logic [15:0] bin_out_re,
  output logic [15:0] bin_out_im,
  output logic        frame_done
);

  localparam int FRAME = NB_BANDS * BINS_PER_BAND;
  localparam int BW = (NB_BANDS > 1) ? $clog2(NB_BANDS) : 1;
  localparam int LW = (BINS_PER_BAND > 1) ? $clog2(BINS_PER_BAND) : 1;
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

`ifdef RNN_GAIN_FLOOR_EN
  localparam bit FLOOR_EN = 1'b1;
`else
  localparam bit FLOOR_EN = 1'b0;
`endif

  typedef enum logic {LOAD, APPLY} state_t;

  state_t      state;
  logic [15:0] gain_buf [NB_BANDS];
  logic [BW-1:0] band_cnt;
  logic [BW-1:0] band_idx;
  logic [LW-1:0] bin_local;
  logic [CW-1:0] bin_cnt;
  logic        in_done;
  logic        out_last;

  logic        gain_fire;
  logic        in_fire;
  logic        out_fire;
  logic        last_bin;
  logic [15:0] g_clamp;
  logic [15:0] g_store;
  logic [15:0] g_sel;
  logic signed [31:0] p_re;
  logic signed [31:0] p_im;

  assign gain_ready = (state == LOAD);
  assign bin_in_ready = (state == APPLY) && !in_done &&
                        (!bin_out_valid || bin_out_ready);

  assign gain_fire = gain_valid && gain_ready;
  assign in_fire   = bin_in_valid && bin_in_ready;
  assign out_fire  = bin_out_valid && bin_out_ready;
  assign last_bin  = (bin_cnt == CW'(FRAME - 1));

  assign g_clamp = gain_data[15] ? 16'h7FFF : gain_data;
  assign g_store = (FLOOR_EN && (g_clamp < GAIN_FLOOR)) ?
                   GAIN_FLOOR : g_clamp;

  assign g_sel = gain_buf[band_idx];

  // gain is at most 0x7FFF, so the product never overflows 32 bits
  assign p_re = $signed({{16{bin_in_re[15]}}, bin_in_re}) *
                $signed({16'h0000, g_sel});
  assign p_im = $signed({{16{bin_in_im[15]}}, bin_in_im}) *
                $signed({16'h0000, g_sel});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOAD;
      band_cnt      <= '0;
      band_idx      <= '0;
      bin_local     <= '0;
      bin_cnt       <= '0;
      in_done       <= 1'b0;
      out_last      <= 1'b0;
      bin_out_valid <= 1'b0;
      bin_out_re    <= '0;
      bin_out_im    <= '0;
      frame_done    <= 1'b0;
      for (int i = 0; i < NB_BANDS; i++) begin
        gain_buf[i] <= '0;
      end
    end else begin
      frame_done <= 1'b0;
      if (out_fire) begin
        bin_out_valid <= 1'b0;
      end
      if (in_fire) begin
        bin_out_valid <= 1'b1;
        bin_out_re    <= 16'(p_re >>> 15);
        bin_out_im    <= 16'(p_im >>> 15);
        out_last      <= last_bin;
        if (last_bin) begin
          in_done   <= 1'b1;
          bin_cnt   <= '0;
          band_idx  <= '0;
          bin_local <= '0;
        end else begin
          bin_cnt <= bin_cnt + 1'b1;
          if (bin_local == LW'(BINS_PER_BAND - 1)) begin
            bin_local <= '0;
            band_idx  <= band_idx + 1'b1;
          end else begin
            bin_local <= bin_local + 1'b1;
          end
        end
      end
      unique case (state)
        LOAD: begin
          if (gain_fire) begin
            gain_buf[band_cnt] <= g_store;
            if (band_cnt == BW'(NB_BANDS - 1)) begin
              band_cnt <= '0;
              state    <= APPLY;
            end else begin
              band_cnt <= band_cnt + 1'b1;
            end
          end
        end
        APPLY: begin
          if (out_fire && out_last) begin
            state      <= LOAD;
            frame_done <= 1'b1;
            in_done    <= 1'b0;
            out_last   <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_gain_apply.sv
// Self-checking bench for rnn_gain_apply.
// Directed frames, random output stalls, mid-frame reset.
module tb_rnn_gain_apply;

  localparam int NB    = 22;
  localparam int BPB   = 8;
  localparam int FRAME = NB * BPB;

  logic        clk;
  logic        rst_n;
  logic        gain_valid;
  logic        gain_ready;
  logic [15:0] gain_data;
  logic        bin_in_valid;
  logic        bin_in_ready;
  logic [15:0] bin_in_re;
  logic [15:0] bin_in_im;
  logic        bin_out_valid;
  logic        bin_out_ready;
  logic [15:0] bin_out_re;
  logic [15:0] bin_out_im;
  logic        frame_done;

  rnn_gain_apply dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gain_valid    (gain_valid),
    .gain_ready    (gain_ready),
    .gain_data     (gain_data),
    .bin_in_valid  (bin_in_valid),
    .bin_in_ready  (bin_in_ready),
    .bin_in_re     (bin_in_re),
    .bin_in_im     (bin_in_im),
    .bin_out_valid (bin_out_valid),
    .bin_out_ready (bin_out_ready),
    .bin_out_re    (bin_out_re),
    .bin_out_im    (bin_out_im),
    .frame_done    (frame_done)
  );

  int checks = 0;
  int errors = 0;

  int          gains [NB];
  logic [15:0] qre [$];
  logic [15:0] qim [$];
  logic [15:0] log_re [FRAME];
  logic [15:0] log_im [FRAME];
  int          out_idx = 0;
  int          fd_count = 0;
  bit          mon_en = 0;
  bit          in_apply = 0;
  bit          stall = 0;
  bit          fd_exp = 0;
  bit          hold_chk = 0;
  logic [15:0] prev_re;
  logic [15:0] prev_im;

  logic [15:0] gv [NB];
  logic [15:0] rv [FRAME];
  logic [15:0] iv [FRAME];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    bin_out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_msg(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for handshake", nm);
  endtask

  // floor(x*g / 2^15) written as integer division with explicit rounding down
  function automatic logic [15:0] scale(input int x, input int g);
    int p;
    int q;
    p = x * g;
    if (p >= 0) q = p / 32768;
    else q = -((-p + 32767) / 32768);
    return 16'(q);
  endfunction

  function automatic int gstore(input logic [15:0] g);
    int v;
    v = g[15] ? 32767 : int'(g);
`ifdef RNN_GAIN_FLOOR_EN
    if (v < 328) v = 328;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("frame_done", {15'd0, frame_done}, {15'd0, fd_exp});
      if (frame_done) begin
        fd_count++;
        in_apply = 0;
      end
      fd_exp = 0;
      if (in_apply) chk("gain_ready_apply", {15'd0, gain_ready}, 16'd0);
      else chk("bin_in_ready_load", {15'd0, bin_in_ready}, 16'd0);
      if (hold_chk) begin
        chk("stall_valid", {15'd0, bin_out_valid}, 16'd1);
        chk("stall_re", bin_out_re, prev_re);
        chk("stall_im", bin_out_im, prev_im);
      end
      if (bin_out_valid && bin_out_ready) begin
        if (qre.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_output: got %h, expected none", bin_out_re);
        end else begin
          chk("out_re", bin_out_re, qre.pop_front());
          chk("out_im", bin_out_im, qim.pop_front());
        end
        log_re[out_idx] = bin_out_re;
        log_im[out_idx] = bin_out_im;
        if (out_idx == FRAME - 1) begin
          fd_exp = 1;
          out_idx = 0;
        end else begin
          out_idx++;
        end
      end
      hold_chk = bin_out_valid && !bin_out_ready;
      prev_re = bin_out_re;
      prev_im = bin_out_im;
    end
  end

  task automatic load_gains(input bit junk);
    int n;
    for (int b = 0; b < NB; b++) begin
      gain_valid = 1'b1;
      gain_data  = gv[b];
      n = 0;
      forever begin
        @(negedge clk);
        if (gain_ready) break;
        if (++n > 200) begin
          fail_msg("gain_load");
          break;
        end
      end
      gains[b] = gstore(gv[b]);
      @(posedge clk);
      #1;
    end
    gain_valid = junk;
    gain_data  = 16'hFFFF;
    in_apply   = 1;
  endtask

  task automatic send_bins(input int count);
    int n;
    for (int k = 0; k < count; k++) begin
      bin_in_valid = 1'b1;
      bin_in_re    = rv[k];
      bin_in_im    = iv[k];
      n = 0;
      forever begin
        @(negedge clk);
        if (bin_in_ready) break;
        if (++n > 200) begin
          fail_msg("bin_in");
          break;
        end
      end
      qre.push_back(scale(int'($signed(rv[k])), gains[k / BPB]));
      qim.push_back(scale(int'($signed(iv[k])), gains[k / BPB]));
      @(posedge clk);
      #1;
      bin_in_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (frame_done) begin
        gain_valid = 1'b0;
        break;
      end
      if (++n > 2000) begin
        fail_msg("frame_done_wait");
        break;
      end
    end
    @(posedge clk);
    #1;
    chk("queue_empty", 16'(qre.size()), 16'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    gain_valid = 1'b0;
    gain_data = '0;
    bin_in_valid = 1'b0;
    bin_in_re = '0;
    bin_in_im = '0;
    bin_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gain_ready", {15'd0, gain_ready}, 16'd1);
    chk("rst_bin_in_ready", {15'd0, bin_in_ready}, 16'd0);
    chk("rst_out_valid", {15'd0, bin_out_valid}, 16'd0);
    chk("rst_out_re", bin_out_re, 16'd0);
    chk("rst_out_im", bin_out_im, 16'd0);
    chk("rst_frame_done", {15'd0, frame_done}, 16'd0);
    rst_n = 1'b1;
    mon_en = 1;

    // frame 1: uniform half gain, no stalls
    for (int b = 0; b < NB; b++) gv[b] = 16'h4000;
    for (int k = 0; k < FRAME; k++) begin
      rv[k] = 16'd1000;
      iv[k] = 16'hFC18;
    end
    load_gains(1'b0);
    send_bins(FRAME);
    wait_done();
    chk("f1_first_re", log_re[0], 16'd500);
    chk("f1_first_im", log_im[0], 16'hFE0C);
    chk("f1_last_re", log_re[FRAME-1], 16'd500);
    chk("f1_fd_count", 16'(fd_count), 16'd1);

    // frame 2: clamp and floor edges, random stalls, gain_valid held high
    for (int b = 0; b < NB; b++) gv[b] = 16'($urandom);
    gv[0] = 16'h8000;
    gv[1] = 16'h7FFF;
    gv[2] = 16'h0001;
    gv[3] = 16'h0000;
    for (int k = 0; k < FRAME; k++) begin
      rv[k] = 16'($urandom);
      iv[k] = 16'($urandom);
    end
    rv[0] = 16'h8000;  iv[0] = 16'h7FFF;
    rv[8] = 16'h7FFF;  iv[8] = 16'hFFFF;
    rv[16] = 16'hFFFF; iv[16] = 16'h7FFF;
    rv[24] = 16'd10000;
    stall = 1;
    load_gains(1'b1);
    send_bins(FRAME);
    wait_done();
    chk("f2_clamp_re", log_re[0], 16'h8001);
    chk("f2_clamp_im", log_im[0], 16'd32766);
    chk("f2_max_re", log_re[8], 16'd32766);
    chk("f2_max_im", log_im[8], 16'hFFFF);
    chk("f2_floor_neg", log_re[16], 16'hFFFF);
`ifdef RNN_GAIN_FLOOR_EN
    chk("f2_gain_floor", log_re[24], 16'd100);
`else
    chk("f2_gain_zero", log_re[24], 16'd0);
`endif
    chk("f2_fd_count", 16'(fd_count), 16'd2);

    // frame 3: abandoned by reset after 50 bins
    for (int b = 0; b < NB; b++) gv[b] = 16'h2000;
    load_gains(1'b0);
    send_bins(50);
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {15'd0, bin_out_valid}, 16'd0);
    chk("mid_rst_gain_ready", {15'd0, gain_ready}, 16'd1);
    chk("mid_rst_in_ready", {15'd0, bin_in_ready}, 16'd0);
    qre.delete();
    qim.delete();
    out_idx = 0;
    fd_exp = 0;
    hold_chk = 0;
    in_apply = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1;

    // frame 4: full new load after reset, random data with stalls
    for (int b = 0; b < NB; b++) gv[b] = 16'($urandom);
    for (int k = 0; k < FRAME; k++) begin
      rv[k] = 16'($urandom);
      iv[k] = 16'($urandom);
    end
    load_gains(1'b1);
    send_bins(FRAME);
    wait_done();
    chk("f4_fd_count", 16'(fd_count), 16'd3);

    stall = 0;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rnn_gain_apply.md
RNN_GAIN_APPLY -- requirements
Module: rnn_gain_apply

Interface
REQ-001 SHALL have parameter NB_BANDS, default 22: band gains per frame.
REQ-002 SHALL have parameter BINS_PER_BAND, default 8: spectrum bins per band; frame length = NB_BANDS*BINS_PER_BAND (176).
REQ-003 SHALL have parameter GAIN_FLOOR, default 16'd328: minimum gain in Q1.15 (about 0.01), used only under RNN_GAIN_FLOOR_EN.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port gain_valid, input, 1: gain_data is valid.
REQ-007 SHALL have port gain_ready, output, 1: block accepts a gain this cycle.
REQ-008 SHALL have port gain_data, input, 16: unsigned Q1.15 band gain, band 0 first.
REQ-009 SHALL have port bin_in_valid, input, 1 / bin_in_ready, output, 1: input bin handshake.
REQ-010 SHALL have port bin_in_re, input, 16 / bin_in_im, input, 16: signed bin components.
REQ-011 SHALL have port bin_out_valid, output, 1 / bin_out_ready, input, 1: output bin handshake.
REQ-012 SHALL have port bin_out_re, output, 16 / bin_out_im, output, 16: signed scaled bin.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when the last bin of a frame is accepted downstream.

Function
REQ-014 SHALL implement FSM states LOAD and APPLY; reset state LOAD.
REQ-015 In LOAD, gain_ready SHALL be 1; each cycle with gain_valid&gain_ready stores gain_data into gain_buf[band_cnt] and increments band_cnt.
REQ-016 A stored gain with bit 15 set SHALL be clamped to 16'h7FFF.
REQ-017 On acceptance of band NB_BANDS-1, the FSM SHALL go to APPLY next cycle and band_cnt SHALL clear.
REQ-018 In APPLY, gain_ready SHALL be 0; gain_valid SHALL be ignored.
REQ-019 bin_in_ready SHALL be 1 only in APPLY while bin_out_valid==0 or bin_out_ready==1; bin_in_ready SHALL be 0 in LOAD.
REQ-020 Bin k of the frame SHALL use gain g = gain_buf[k / BINS_PER_BAND]; a bin counter and a band-local counter SHALL track position.
REQ-021 Output SHALL be re*g and im*g, 32-bit signed product, arithmetic-shifted right 15 (floor), low 16 bits; no saturation needed.
REQ-022 Latency SHALL be 1 cycle: accepted input appears on registered bin_out_* with bin_out_valid=1 the next cycle.
REQ-023 While bin_out_valid==1 and bin_out_ready==0, bin_out_* SHALL hold stable and no input SHALL be accepted.
REQ-024 Simultaneous output acceptance and input acceptance SHALL replace the output register with no bubble.
REQ-025 After the last frame bin is accepted at the input, bin_in_ready SHALL drop; when that bin is accepted downstream, frame_done SHALL pulse and the FSM SHALL return to LOAD.
REQ-026 Gains for frame n+1 SHALL NOT be accepted before frame_done of frame n.

Reset
REQ-027 On rst_n low, outputs SHALL reset to: gain_ready=1 (state LOAD), bin_in_ready=0, bin_out_valid=0, bin_out_re=0, bin_out_im=0, frame_done=0; all counters and gain_buf SHALL clear to 0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release the block SHALL expect a full new set of NB_BANDS gains.

Configuration
REQ-029 With macro RNN_GAIN_FLOOR_EN defined, gains SHALL be stored as max(clamped gain, GAIN_FLOOR); without it, gains SHALL be stored unmodified apart from the REQ-016 clamp.

Verification
REQ-030 Load 22 gains of 16'h4000, stream 176 bins re=1000, im=-1000 with ready=1 -> outputs re=500, im=-500, frame_done after the 176th output.
REQ-031 Band 0 gain 16'h7FFF, bin re=-32768 -> out re=-32767; gain 16'h8000 -> stored 16'h7FFF.
REQ-032 Random bin_out_ready stalls -> zero loss/duplication, outputs stable during stall, order preserved.
REQ-033 Gain 0 with RNN_GAIN_FLOOR_EN defined, bin re=10000 -> out re=100; macro undefined -> out re=0.
REQ-034 rst_n low after 50 bins -> bin_out_valid=0 immediately, gain_ready=1; a new 22-gain load and 176-bin frame complete correctly.
REQ-035 gain_valid held high during APPLY -> gain_ready=0 and gain_buf unchanged until frame_done.
